// File: rtl/mont_pkg.sv
// mont_pkg: shared state encoding and constants for the Montgomery-domain blocks
package mont_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, REDUCE, SCALE, DONE} conv_state_t;
  localparam logic [1:0] MIN_MODULO = 2'd3;
endpackage

// File: rtl/mod_shift_sub.sv
// mod_shift_sub: (2*r + bit_in) mod n with one conditional subtract, valid while r < n
module mod_shift_sub #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic             bit_in_i,
  output logic [WIDTH-1:0] res_o
);
  logic [WIDTH:0] t, d;
  assign t = {r_i, bit_in_i};
  assign d = t - {1'b0, n_i};
  assign res_o = (t >= {1'b0, n_i}) ? d[WIDTH-1:0] : t[WIDTH-1:0];
endmodule

// File: rtl/mont_converter.sv
// mont_converter: bit-serial value*R mod N and R mod N with R = 2^WIDTH
module mont_converter
  import mont_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0] modulo,
  input  logic             valid_in,
  output logic [WIDTH-1:0] mont_out,
  output logic [WIDTH-1:0] one_mont_out,
  output logic             valid_out,
  output logic             error_out,
  output logic             busy_out
);
  localparam int CW = $clog2(WIDTH);
  conv_state_t state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d, mod_q, mod_d, acc_q, acc_d, one_q, one_d;
  logic [WIDTH-1:0] mont_q, mont_d, one_mont_q, one_mont_d, acc_nx, one_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, error_q, error_d, busy_q, busy_d;
  logic last, illegal;
  assign last = cnt_q == CW'(WIDTH - 1);
  assign illegal = !mod_q[0] || (mod_q < WIDTH'(MIN_MODULO));
  mod_shift_sub #(.WIDTH(WIDTH)) u_acc (
    .r_i(acc_q), .n_i(mod_q), .bit_in_i(state_q == REDUCE && value_q[WIDTH-1]), .res_o(acc_nx)
  );
  mod_shift_sub #(.WIDTH(WIDTH)) u_one (
    .r_i(one_q), .n_i(mod_q), .bit_in_i(1'b0), .res_o(one_nx)
  );
  assign mont_out = mont_q;
  assign one_mont_out = one_mont_q;
  assign valid_out = valid_q;
  assign error_out = error_q;
  assign busy_out = busy_q;
  // state and datapath registers, cleared by the active-low synchronous reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      value_q <= '0;
      mod_q <= '0;
      acc_q <= '0;
      one_q <= '0;
      mont_q <= '0;
      one_mont_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      mod_q <= mod_d;
      acc_q <= acc_d;
      one_q <= one_d;
      mont_q <= mont_d;
      one_mont_q <= one_mont_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q <= busy_d;
    end
  end
  // sequencing: operand latch, legality check, WIDTH reduce steps, WIDTH doubling steps
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    mod_d = mod_q;
    acc_d = acc_q;
    one_d = one_q;
    mont_d = mont_q;
    one_mont_d = one_mont_q;
    cnt_d = cnt_q;
    valid_d = 1'b0;
    error_d = error_q;
    busy_d = busy_q;
    case (state_q)
      IDLE: if (valid_in) begin
        value_d = value_in;
        mod_d = modulo;
        busy_d = 1'b1;
        state_d = CHECK;
      end
      CHECK: if (illegal) begin
        mont_d = '0;
        one_mont_d = '0;
        error_d = 1'b1;
        valid_d = 1'b1;
        busy_d = 1'b0;
        state_d = DONE;
      end else begin
        acc_d = '0;
        one_d = WIDTH'(1);
        cnt_d = '0;
        state_d = REDUCE;
      end
      REDUCE: begin
        acc_d = acc_nx;
        value_d = value_q << 1;
        cnt_d = last ? '0 : cnt_q + CW'(1);
        state_d = last ? SCALE : REDUCE;
      end
      SCALE: begin
        acc_d = acc_nx;
        one_d = one_nx;
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          mont_d = acc_nx;
          one_mont_d = one_nx;
          error_d = 1'b0;
          valid_d = 1'b1;
          busy_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mont_converter.sv
// tb_mont_converter: randomized checks of mont_converter at WIDTH=8 and WIDTH=512 against an arithmetic model
module tb_mont_converter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst8, vin8, vo8, e8, b8;
  logic [7:0] v8, n8, m8, o8;
  logic rst512, vin512, vo512, e512, b512;
  logic [511:0] v512, n512, m512, o512;
  int n_chk = 0;
  int n_pass = 0;
  mont_converter #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_in(rst8), .value_in(v8), .modulo(n8), .valid_in(vin8),
    .mont_out(m8), .one_mont_out(o8), .valid_out(vo8), .error_out(e8), .busy_out(b8)
  );
  mont_converter #(.WIDTH(512)) dut512 (
    .clk_in(clk), .rst_in(rst512), .value_in(v512), .modulo(n512), .valid_in(vin512),
    .mont_out(m512), .one_mont_out(o512), .valid_out(vo512), .error_out(e512), .busy_out(b512)
  );
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [511:0] mm512(input logic [511:0] v, input logic [511:0] n);
    logic [1024:0] t, nn;
    nn = {513'b0, n};
    t = {513'b0, v} % nn;
    t = (t << 512) % nn;
    return t[511:0];
  endfunction
  function automatic logic [511:0] one512(input logic [511:0] n);
    logic [1024:0] t;
    t = 1025'd1;
    t = (t << 512) % {513'b0, n};
    return t[511:0];
  endfunction
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic job8(input logic [7:0] v, input logic [7:0] n, input bit flood);
    int k, pulses, lat;
    logic [7:0] em, eo;
    logic ee;
    string t;
    ee = !n[0] || n == 8'd1;
    em = ee ? 8'd0 : 8'(((int'(v) % int'(n)) * 256) % int'(n));
    eo = ee ? 8'd0 : 8'(256 % int'(n));
    lat = ee ? 1 : 17;
    t = $sformatf("w8 v=%0d n=%0d", v, n);
    @(negedge clk);
    v8 = v; n8 = n; vin8 = 1'b1;
    @(negedge clk);
    if (!flood) vin8 = 1'b0;
    v8 = ~v; n8 = 8'd2;
    check({t, " busy"}, 512'(b8), 512'(1));
    k = 0;
    while (!vo8 && k < 100) begin
      @(negedge clk);
      k++;
    end
    vin8 = 1'b0;
    check({t, " latency"}, 512'(k), 512'(lat));
    check({t, " valid"}, 512'(vo8), 512'(1));
    check({t, " mont"}, 512'(m8), 512'(em));
    check({t, " one"}, 512'(o8), 512'(eo));
    check({t, " err"}, 512'(e8), 512'(ee));
    check({t, " busy_done"}, 512'(b8), 512'(0));
    @(negedge clk);
    check({t, " valid_drop"}, 512'(vo8), 512'(0));
    check({t, " mont_hold"}, 512'(m8), 512'(em));
    check({t, " err_hold"}, 512'(e8), 512'(ee));
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (vo8) pulses++;
    end
    check({t, " extra_valid"}, 512'(pulses), 512'(0));
  endtask
  task automatic job512(input logic [511:0] v, input logic [511:0] n);
    int k;
    logic [511:0] em, eo;
    em = mm512(v, n);
    eo = one512(n);
    @(negedge clk);
    v512 = v; n512 = n; vin512 = 1'b1;
    @(negedge clk);
    vin512 = 1'b0; v512 = '0; n512 = '0;
    k = 0;
    while (!vo512 && k < 1200) begin
      @(negedge clk);
      k++;
    end
    check("w512 latency", 512'(k), 512'(1025));
    check("w512 mont", m512, em);
    check("w512 one", o512, eo);
    check("w512 err", 512'(e512), 512'(0));
    check("w512 busy", 512'(b512), 512'(0));
  endtask
  initial begin
    int k, pulses;
    logic [511:0] n, v;
    rst8 = 1'b0; vin8 = 1'b0; v8 = '0; n8 = '0;
    rst512 = 1'b0; vin512 = 1'b0; v512 = '0; n512 = '0;
    repeat (3) @(negedge clk);
    check("rst mont8", 512'({m8, o8}), 512'(0));
    check("rst flags8", 512'({vo8, e8, b8}), 512'(0));
    check("rst mont512", m512 | o512, 512'(0));
    check("rst flags512", 512'({vo512, e512, b512}), 512'(0));
    rst8 = 1'b1; rst512 = 1'b1;
    job8(8'd5, 8'd13, 1'b0);
    job8(8'd200, 8'd13, 1'b0);
    job8(8'd0, 8'd13, 1'b0);
    job8(8'd254, 8'd255, 1'b1);
    job8(8'd5, 8'd12, 1'b0);
    job8(8'd5, 8'd1, 1'b0);
    job8(8'd5, 8'd13, 1'b0);
    @(negedge clk);
    v8 = 8'd7; n8 = 8'd11; vin8 = 1'b1;
    @(negedge clk);
    vin8 = 1'b0;
    repeat (12) @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    check("abort mont", 512'({m8, o8}), 512'(0));
    check("abort flags", 512'({vo8, e8, b8}), 512'(0));
    rst8 = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (vo8) pulses++;
    end
    check("abort no_valid", 512'(pulses), 512'(0));
    job8(8'd5, 8'd13, 1'b0);
    for (int i = 0; i < 12; i++)
      job8(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) begin
      n = rnd512();
      n[0] = 1'b1;
      if (i == 2) n[511:64] = '0;
      else n[511] = 1'b1;
      v = rnd512();
      job512(v, n);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
